// File: rtl/nv_ram_pkg.sv
// -----------------------------------------------------------------------------
// nv_ram_pkg
// Shared types and constants for the parametrised two-port RAM
// (nv_ram_rwsthp_param) and its post-reset clear engine.
//   ram_state_e     : clear engine state (CLEAR while zeroing, READY after)
//   RDW_WRITE_FIRST : same-address read during write returns the new data
//   RDW_READ_FIRST  : same-address read during write returns the old data
//   PD_SLEEP_BIT    : bit of pwrbus_ram_pd that puts the macro to sleep
// -----------------------------------------------------------------------------
package nv_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    localparam int PD_SLEEP_BIT = 0;

endpackage

// File: rtl/nv_ram_rwsthp_param_if.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsthp_param_if
// Bundles the read port, write port, bypass, power and status signals of the
// RAM.
//   master : drives ra/re/ore, wa/we/di, byp_sel/dbyp, pwrbus_ram_pd;
//            observes dout, init_busy, wr_drop
//   slave  : the RAM itself (mirror image of master)
// Handshake semantics: there is no back-pressure. re, we and ore are
// qualifiers sampled on every rising clk edge; a request is either taken
// at that edge or discarded (a discarded write raises wr_drop for exactly
// one cycle, a discarded read leaves rd_data unchanged). init_busy is a
// status level, not a ready signal: requests made while it is high are
// dropped, not stalled.
// -----------------------------------------------------------------------------
interface nv_ram_rwsthp_param_if #(
    parameter int DEPTH = 80,
    parameter int WIDTH = 72
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] di;
    logic             byp_sel;
    logic [WIDTH-1:0] dbyp;
    logic [31:0]      pwrbus_ram_pd;
    logic             init_busy;
    logic             wr_drop;

    modport master (
        output ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        input  dout, init_busy, wr_drop
    );

    modport slave (
        input  ra, re, ore, wa, we, di, byp_sel, dbyp, pwrbus_ram_pd,
        output dout, init_busy, wr_drop
    );

endinterface

// File: rtl/nv_ram_clear_fsm.sv
// -----------------------------------------------------------------------------
// nv_ram_clear_fsm
// Post-reset clear engine: walks the address space once, issuing one zero
// write per non-sleep cycle, then parks in READY until the next reset.
//   clk, rst  : core clock, asynchronous active-high reset
//   sleep     : pauses the walk (no write, counter held)
//   clr_we    : write strobe for the array (only while CLEAR and awake)
//   clr_addr  : address being cleared
//   init_busy : high while in CLEAR
//   ready     : high in READY (array open to normal traffic)
// -----------------------------------------------------------------------------
module nv_ram_clear_fsm
    import nv_ram_pkg::*;
#(
    parameter int DEPTH      = 80,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sleep,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          init_busy,
    output logic          ready
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam ram_state_e    RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

    ram_state_e    state;
    ram_state_e    state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                if (!sleep) begin
                    clr_we = 1'b1;
                    // Leave on the edge that writes the last entry, so the
                    // clear takes exactly DEPTH awake cycles.
                    if (cnt == LAST) begin
                        state_nxt = READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + AW'(1);
                    end
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    assign clr_addr  = cnt;
    assign init_busy = (state == CLEAR);
    assign ready     = (state == READY);

endmodule

// File: rtl/nv_ram_rwsthp_param.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsthp_param
// Parametrised 1R1W RAM with a registered read stage (rd_data), an output
// register (dout) loaded under ore, and an output bypass (byp_sel/dbyp).
// Adds a post-reset clear engine, selectable read-during-write policy,
// sleep via pwrbus_ram_pd[0], out-of-range protection and a write-drop pulse.
//   clk, rst : core clock, asynchronous active-high reset
//   ram      : slave side of nv_ram_rwsthp_param_if (read/write ports,
//              bypass, power control, init_busy, wr_drop)
// Parameters: DEPTH, WIDTH, INIT_CLEAR (zero array after reset),
//             RDW_MODE (0 = write-first, 1 = read-first).
// -----------------------------------------------------------------------------
module nv_ram_rwsthp_param
    import nv_ram_pkg::*;
#(
    parameter int DEPTH      = 80,
    parameter int WIDTH      = 72,
    parameter int INIT_CLEAR = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    nv_ram_rwsthp_param_if.slave  ram
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             sleep;
    logic             acc;
    logic             ready;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wa_ok;
    logic             ra_ok;
    logic             wr_ok;
    logic             arr_we;
    logic [AW-1:0]    arr_addr;
    logic [WIDTH-1:0] arr_wdata;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] dout_q;
    logic             wr_drop_q;
    logic             unused_pd;

    // Bits 31:1 of the power bus are reserved.
    assign unused_pd = ^ram.pwrbus_ram_pd[31:1];

    assign sleep = ram.pwrbus_ram_pd[PD_SLEEP_BIT];
    assign acc   = ready & ~sleep;
    assign wa_ok = ({1'b0, ram.wa} < DEPTH_V);
    assign ra_ok = ({1'b0, ram.ra} < DEPTH_V);
    assign wr_ok = ram.we & acc & wa_ok;

    nv_ram_clear_fsm #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .sleep     (sleep),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (ram.init_busy),
        .ready     (ready)
    );

    // clr_we only occurs in CLEAR and wr_ok only in READY, so the two
    // write sources never collide.
    assign arr_we    = clr_we | wr_ok;
    assign arr_addr  = clr_we ? clr_addr : ram.wa;
    assign arr_wdata = clr_we ? '0 : ram.di;

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            dout_q    <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            if (ram.re && acc) begin
                if (!ra_ok) begin
                    rd_data <= '0;
                end else if ((RDW_MODE == RDW_WRITE_FIRST) && wr_ok &&
                             (ram.wa == ram.ra)) begin
                    rd_data <= ram.di;
                end else begin
                    // Read-first falls out naturally: mem still holds the
                    // old word at this edge.
                    rd_data <= mem[ram.ra];
                end
            end
            wr_drop_q <= ram.we & ~wr_ok;
            if (ram.ore && !sleep) begin
                dout_q <= ram.byp_sel ? ram.dbyp : rd_data;
            end
        end
    end

    assign ram.dout    = dout_q;
    assign ram.wr_drop = wr_drop_q;

endmodule
